// File: rtl/led_pattern_arbiter.sv
// led_pattern_arbiter: round-robin owner of the single status LED; plays the
// winner's pattern LSB-first, each bit held BIT_CYCLES clocks.
// Ports: CLK, RST_N (sync, active low), REQ[NUM_REQ], PATTERN[NUM_REQ*PAT_W]
//        -> GRANT (one-hot), BUSY, DONE (1-cycle pulse), LED. All registered.
module led_pattern_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int PAT_W      = 16,
  parameter int BIT_CYCLES = 2_000_000
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*PAT_W-1:0] PATTERN,
  output logic [NUM_REQ-1:0]       GRANT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     LED
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PAT_W - 1);
  localparam logic [RW-1:0] LAST_RST = RW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        last_q,  last_d;
  logic [PAT_W-1:0]     pat_q,   pat_d;
  logic [IW-1:0]        idx_q,   idx_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic                 led_q,   led_d;

  logic                 found;
  logic [RW-1:0]        cand;
  logic [RW-1:0]        win;
  logic [PAT_W-1:0]     win_pat;

  // Round-robin search: start just after the last winner, ascend with wrap.
  always_comb begin : arb
    found = 1'b0;
    cand  = '0;
    win   = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = RW'((int'(last_q) + k) % NUM_REQ);
      if (!found && REQ[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_pat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == RW'(i)) begin
        win_pat = PATTERN[i*PAT_W +: PAT_W];
      end
    end
  end

  // pat_q is a shift register: bit 0 always holds the bit now on the LED,
  // so the next bit to show is pat_q[1].
  always_comb begin : fsm
    state_d = state_q;
    last_d  = last_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    led_d   = led_q;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        led_d   = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
        if (found) begin
          state_d = PLAY;
          last_d  = win;
          pat_d   = win_pat;
          grant_d = NUM_REQ'(1) << win;
          busy_d  = 1'b1;
          led_d   = win_pat[0];
        end
      end
      PLAY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            grant_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            led_d   = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
            pat_d = pat_q >> 1;
            led_d = pat_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      pat_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  assign GRANT = grant_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign LED   = led_q;

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// tb_led_pattern_arbiter: directed + random stimulus; expected outputs per
// cycle come from a behavioural model and are checked by a separate monitor.
module tb_led_pattern_arbiter;

  localparam int NR  = 4;
  localparam int PW  = 8;
  localparam int BC  = 4;
  localparam int DUR = PW * BC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*PW-1:0]  pat;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              done;
  logic              led;

  led_pattern_arbiter #(
    .NUM_REQ   (NR),
    .PAT_W     (PW),
    .BIT_CYCLES(BC)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .REQ    (req),
    .PATTERN(pat),
    .GRANT  (grant),
    .BUSY   (busy),
    .DONE   (done),
    .LED    (led)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] exp_q[$];

  bit          m_play;
  bit          m_done;
  int          m_owner;
  int          m_el;
  int          m_last;
  logic [PW-1:0] m_pat;

  task automatic model_step(input logic r, input logic [NR-1:0] q,
                            input logic [NR*PW-1:0] p);
    if (!r) begin
      m_play = 0;
      m_done = 0;
      m_el   = 0;
      m_last = NR - 1;
    end else if (m_play) begin
      if (m_el == DUR - 1) begin
        m_play = 0;
        m_done = 1;
      end else begin
        m_el++;
      end
    end else begin
      m_done = 0;
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (q[c]) begin
          m_play  = 1;
          m_owner = c;
          m_last  = c;
          m_pat   = p[c*PW +: PW];
          m_el    = 0;
          break;
        end
      end
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [NR-1:0] g;
    logic          l;
    g = m_play ? NR'(1 << m_owner) : '0;
    l = m_play ? m_pat[m_el / BC] : 1'b0;
    return {g, logic'(m_play), logic'(m_done), l};
  endfunction

  task automatic drive(input logic r, input logic [NR-1:0] q,
                       input logic [NR*PW-1:0] p);
    rst_n = r;
    req   = q;
    pat   = p;
    model_step(r, q, p);
    exp_q.push_back(model_out());
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [6:0] want);
    logic [6:0] act;
    act = {grant, busy, done, led};
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got {grant,busy,done,led}=%b want %b",
               nm, $time, act, want);
    end
  endtask

  initial begin : monitor
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({grant, busy, done, led} !== e) begin
          n_bad++;
          $display("FAIL cycle_check t=%0t: got {grant,busy,done,led}=%b want %b",
                   $time, {grant, busy, done, led}, e);
        end
      end
    end
  end

  initial begin : driver
    logic [NR*PW-1:0] p;
    logic [NR*PW-1:0] p2;
    logic [NR-1:0]    q;
    logic             r;
    p  = 32'h3C0F_F0A5;
    p2 = p ^ 32'h00FF_0000;

    drive(0, 4'hF, p);
    tick();
    drive(0, 4'hF, p);
    tick();
    drive(0, 4'hF, p);
    tick();
    chk("reset_outs", 7'b0000_0_0_0);
    drive(1, 4'hF, p);
    tick();
    chk("first_grant", {4'b0001, 1'b1, 1'b0, 1'b1});
    repeat (31) begin
      drive(1, 4'hF, p);
      tick();
    end
    chk("last_bit", {4'b0001, 1'b1, 1'b0, 1'b1});
    drive(1, 4'hF, p);
    tick();
    chk("done_cycle", {4'b0000, 1'b0, 1'b1, 1'b0});
    drive(1, 4'hF, p);
    tick();
    chk("rr_second", {4'b0010, 1'b1, 1'b0, 1'b0});
    repeat (33 * 3) begin
      drive(1, 4'hF, p);
      tick();
    end
    chk("rr_wrap", {4'b0001, 1'b1, 1'b0, 1'b1});

    drive(0, 4'h0, p);
    tick();
    drive(1, 4'b0001, p);
    tick();
    chk("single_grant", {4'b0001, 1'b1, 1'b0, 1'b1});
    repeat (34) begin
      drive(1, 4'h0, p);
      tick();
    end

    drive(0, 4'h0, p);
    tick();
    drive(1, 4'b0100, p);
    tick();
    repeat (8) begin
      drive(1, 4'b0100, p);
      tick();
    end
    repeat (24) begin
      drive(1, 4'h0, p2);
      tick();
    end
    chk("drop_done", {4'b0000, 1'b0, 1'b1, 1'b0});

    drive(0, 4'h0, p);
    tick();
    drive(1, 4'b0100, p);
    tick();
    repeat (12) begin
      drive(1, 4'h0, p);
      tick();
    end
    drive(0, 4'h0, p);
    tick();
    chk("mid_reset", 7'b0000_0_0_0);
    drive(1, 4'b1100, p);
    tick();
    chk("ptr_reset", {4'b0100, 1'b1, 1'b0, 1'b1});
    repeat (33) begin
      drive(1, 4'h0, p);
      tick();
    end

    drive(0, 4'h0, p);
    tick();
    drive(1, 4'b0010, p);
    tick();
    repeat (31) begin
      drive(1, 4'h0, p);
      tick();
    end
    drive(1, 4'h0, p);
    tick();
    chk("req_on_done", {4'b0000, 1'b0, 1'b1, 1'b0});
    drive(1, 4'b0001, p);
    tick();
    chk("grant_after_done", {4'b0001, 1'b1, 1'b0, 1'b1});

    repeat (3000) begin
      r = ($urandom % 300) != 0;
      q = (($urandom % 3) == 0) ? NR'($urandom) : '0;
      p = $urandom;
      drive(r, q, p);
      tick();
    end

    drive(1, 4'h0, p);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
